// File: rtl/id_ex_pipeline_register.sv
// id_ex_pipeline_register: Decode->Execute stage register with stall hold and bubble insertion.
package id_ex_pkg;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef enum logic [2:0] {
    ALUOP_NONE, ALUOP_ADD, ALUOP_RTYPE, ALUOP_ITYPE_ARITH, ALUOP_BRANCH, ALUOP_LUI, ALUOP_AUIPC
  } alu_op_e;
endpackage

module id_ex_pipeline_register
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stall_i,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic                      RegWrite_i,
  input  logic                      MemRead_i,
  input  logic                      MemWrite_i,
  input  logic                      Branch_i,
  input  logic                      Jump_i,
  input  logic                      ALUSrc1_i,
  input  logic                      ALUSrc2_i,
  input  wb_sel_e                   WBSel_i,
  input  alu_op_e                   ALUOp_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_i,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic [DATA_WIDTH-1:0]     imm_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [2:0]                funct3_i,
  input  logic [6:0]                funct7_i,
  output logic                      valid_o,
  output logic                      RegWrite_o,
  output logic                      MemRead_o,
  output logic                      MemWrite_o,
  output logic                      Branch_o,
  output logic                      Jump_o,
  output logic                      ALUSrc1_o,
  output logic                      ALUSrc2_o,
  output wb_sel_e                   WBSel_o,
  output alu_op_e                   ALUOp_o,
  output logic [DATA_WIDTH-1:0]     pc_o,
  output logic [DATA_WIDTH-1:0]     pc_plus4_o,
  output logic [DATA_WIDTH-1:0]     rs1_data_o,
  output logic [DATA_WIDTH-1:0]     rs2_data_o,
  output logic [DATA_WIDTH-1:0]     imm_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [2:0]                funct3_o,
  output logic [6:0]                funct7_o
);
  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      branch;
    logic                      jump;
    logic                      alu_src1;
    logic                      alu_src2;
    wb_sel_e                   wb_sel;
    alu_op_e                   alu_op;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
  } id_ex_t;

  id_ex_t in_s, stage_d, stage_q;

  // All-zero is the bubble: NONE encodings are 0, so '0 covers reset and flush alike.
  always_comb begin
    in_s = '{
      valid: 1'b1, reg_write: RegWrite_i, mem_read: MemRead_i, mem_write: MemWrite_i,
      branch: Branch_i, jump: Jump_i, alu_src1: ALUSrc1_i, alu_src2: ALUSrc2_i,
      wb_sel: WBSel_i, alu_op: (ALUOp_i > ALUOP_AUIPC) ? ALUOP_NONE : ALUOp_i,
      pc: pc_i, pc_plus4: pc_plus4_i, rs1_data: rs1_data_i, rs2_data: rs2_data_i, imm: imm_i,
      rs1_addr: rs1_addr_i, rs2_addr: rs2_addr_i, rd_addr: rd_addr_i,
      funct3: funct3_i, funct7: funct7_i
    };
    stage_d = flush_i ? '0 : stall_i ? stage_q : valid_i ? in_s : '0;
  end

  always_ff @(posedge clk_i)
    if (rst_i) stage_q <= '0;
    else stage_q <= stage_d;

  assign valid_o    = stage_q.valid;
  assign RegWrite_o = stage_q.reg_write;
  assign MemRead_o  = stage_q.mem_read;
  assign MemWrite_o = stage_q.mem_write;
  assign Branch_o   = stage_q.branch;
  assign Jump_o     = stage_q.jump;
  assign ALUSrc1_o  = stage_q.alu_src1;
  assign ALUSrc2_o  = stage_q.alu_src2;
  assign WBSel_o    = stage_q.wb_sel;
  assign ALUOp_o    = stage_q.alu_op;
  assign pc_o       = stage_q.pc;
  assign pc_plus4_o = stage_q.pc_plus4;
  assign rs1_data_o = stage_q.rs1_data;
  assign rs2_data_o = stage_q.rs2_data;
  assign imm_o      = stage_q.imm;
  assign rs1_addr_o = stage_q.rs1_addr;
  assign rs2_addr_o = stage_q.rs2_addr;
  assign rd_addr_o  = stage_q.rd_addr;
  assign funct3_o   = stage_q.funct3;
  assign funct7_o   = stage_q.funct7;
endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
Pipeline register between Decode and Execute. It captures the main control unit's decoded control signals plus the decode datapath: PC, PC+4, register operands, immediate, register addresses and funct fields. It supports hazard stall (hold) and branch/jump flush (bubble insertion). Every output is registered, so Execute sees a stable one-cycle-delayed copy of Decode.

Parameters:
DATA_WIDTH, 32, width of PC, operand and immediate fields
REG_ADDR_WIDTH, 5, width of rs1/rs2/rd addresses

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_i  in  1  synchronous, active-high reset
stall_i  in  1  hazard unit: hold current contents
flush_i  in  1  branch/jump redirect or load-use: insert bubble
valid_i  in  1  Decode holds a real instruction
RegWrite_i/MemRead_i/MemWrite_i/Branch_i/Jump_i/ALUSrc1_i/ALUSrc2_i  in  1 each  decoded control bits
WBSel_i  in  wb_sel_e  write-back select
ALUOp_i  in  alu_op_e  ALU operation class
pc_i, pc_plus4_i, rs1_data_i, rs2_data_i, imm_i  in  DATA_WIDTH each  Decode datapath values
rs1_addr_i, rs2_addr_i, rd_addr_i  in  REG_ADDR_WIDTH each  register addresses
funct3_i  in  3  instruction funct3
funct7_i  in  7  instruction funct7
valid_o and every *_i above mirrored as *_o  out  same widths/types  registered Execute-side copies

Behaviour:
- Reset (rst_i=1 at a clock edge): every 1-bit control output and valid_o = 0. WBSel_o = WB_NONE, ALUOp_o = ALUOP_NONE. All datapath, address and funct outputs = 0.
- Per-edge priority: rst_i > flush_i > stall_i > load.
- Flush (flush_i=1): load a bubble. valid_o=0, RegWrite_o=MemRead_o=MemWrite_o=Branch_o=Jump_o=ALUSrc1_o=ALUSrc2_o=0, WBSel_o=WB_NONE, ALUOp_o=ALUOP_NONE, all datapath/address/funct outputs = 0. This applies whatever stall_i is.
- Stall (stall_i=1, flush_i=0): every output keeps its value. Inputs are ignored.
- Load (stall_i=0, flush_i=0): every output takes its input on the next edge, giving 1-cycle latency.
- valid_i=0 on load: behave exactly as a flush. A non-valid instruction must never carry RegWrite/MemWrite/Branch/Jump into Execute.
- Invariant: valid_o=0 implies all side-effect controls (RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o) are 0.
- Reset overrides an in-progress stall. After rst_i deasserts, the first edge with stall_i=0 and flush_i=0 loads normally.
- No combinational path from any input to any output.
- rd_addr_o is passed through even when it is x0. Suppressing writes to x0 is done downstream and is not this block's job.
- Enum outputs must only ever hold a legal enum member or the NONE value.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with random inputs -> all outputs 0, WBSel_o=WB_NONE, ALUOp_o=ALUOP_NONE, valid_o=0.
- Load: valid_i=1, RegWrite_i=1, ALUSrc2_i=1, ALUOp_i=ALUOP_ITYPE_ARITH, WBSel_i=WB_ALU, pc_i=0x0000_0040, imm_i=0xFFFF_FFFC, rd_addr_i=5 -> next cycle the outputs equal these values and valid_o=1.
- Stall: load a store (MemWrite_i=1, pc_i=0x100). Then stall_i=1 for 3 cycles while the inputs change to pc_i=0x104/0x108 -> outputs stay at pc_o=0x100, MemWrite_o=1. Release the stall -> the current inputs load on the next edge.
- Flush vs stall: stall_i=1 and flush_i=1 together while holding a JAL (Jump_o=1, WBSel_o=WB_PC4) -> next cycle valid_o=0, Jump_o=0, RegWrite_o=0, WBSel_o=WB_NONE, pc_o=0.
- Invalid input: valid_i=0 with RegWrite_i=1, Branch_i=1, rd_addr_i=7 -> next cycle valid_o=0, RegWrite_o=0, Branch_o=0, rd_addr_o=0.
- Reset mid-stall: stall active holding a load (MemRead_o=1), assert rst_i for 1 cycle -> all outputs cleared. Then deassert rst_i and stall_i -> the next instruction loads normally.
